// File: rtl/decoder_pkg.sv
// Shared decoder definitions: datapath widths used by decoder_core and its
// output serializer, plus the serializer state encoding.
package decoder_pkg;

  localparam int DEC_IN_W   = 80;
  localparam int DEC_OUT_W  = 224;
  localparam int SER_WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/decoder_result_fifo.sv
// Small circular result buffer; the count disambiguates full from empty and
// the head entry is presented straight from storage.
module decoder_result_fifo
  import decoder_pkg::*;
#(
  parameter int W     = DEC_OUT_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == LVL_W'(DEPTH));
  assign empty = (count_q == LVL_W'(0));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/decoder_out_serializer.sv
// Buffers decoder_core results and streams each one LSB-first as NW words
// over valid/ready, counting sent frames and flagging dropped results.
module decoder_out_serializer
  import decoder_pkg::*;
#(
  parameter int DATA_W = DEC_OUT_W,
  parameter int WORD_W = SER_WORD_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int NW    = DATA_W / WORD_W;
  localparam int IDX_W = idx_width(NW);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  ser_state_e        state_q, state_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;

  logic              beat, last_word, pop, push, drop;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  decoder_result_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // A full FIFO still accepts a result when the head frame leaves that cycle.
  always_comb begin
    beat      = (state_q == ST_SEND) & m_ready;
    last_word = (widx_q == IDX_W'(NW - 1));
    pop       = beat & last_word;
    push      = valid_in & (~fifo_full | pop);
    drop      = valid_in & fifo_full & ~pop;
  end

  // Serializer FSM, word index, frame counter and sticky drop flag.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q | drop;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (pop) begin
          widx_d      = '0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if ((fifo_count == LVL_W'(1)) && !push) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else if (beat) begin
          widx_d = widx_q + IDX_W'(1);
        end else begin
          widx_d = widx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        widx_d  = '0;
      end
    endcase
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Every output derives from registers only, so the stall hold is implicit.
  assign m_valid    = (state_q == ST_SEND);
  assign m_last     = m_valid & last_word;
  assign m_data     = fifo_head[widx_q * WORD_W +: WORD_W];
  assign frame_cnt  = frame_cnt_q;
  assign overflow   = overflow_q;
  assign fifo_level = fifo_count;

endmodule

// File: tb/tb_decoder_out_serializer.sv
// Randomized and directed bench for decoder_out_serializer against a
// queue-based reference model of the result buffer and word streaming.
module tb_decoder_out_serializer;

  localparam int DATA_W = 224;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 2;
  localparam int NW     = DATA_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              valid_in = 1'b0;
  logic              m_ready = 1'b0;

  logic [WORD_W-1:0] m_data, c2_m_data;
  logic              m_valid, c2_m_valid;
  logic              m_last, c2_m_last;
  logic [15:0]       frame_cnt;
  logic [1:0]        c2_frame_cnt;
  logic              overflow, c2_overflow;
  logic [1:0]        fifo_level, c2_fifo_level;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] mq[$];
  int                widx_m = 0;
  int                frames_m = 0;
  bit                ovf_m = 1'b0;

  logic [WORD_W-1:0] log_d[$];
  bit                log_l[$];
  bit                prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_data;
  bit                prev_last;

  decoder_out_serializer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_cnt(frame_cnt), .overflow(overflow), .fifo_level(fifo_level)
  );

  decoder_out_serializer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .m_data(c2_m_data), .m_valid(c2_m_valid), .m_ready(m_ready), .m_last(c2_m_last),
    .frame_cnt(c2_frame_cnt), .overflow(c2_overflow), .fifo_level(c2_fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit r);
    logic [DATA_W-1:0] h;
    logic [WORD_W-1:0] exp_w;
    bit                exp_l;
    bit                beat, pop, full;
    @(negedge clk);
    exp_w = '0;
    exp_l = 1'b0;
    if (mq.size() != 0) begin
      h     = mq[0];
      exp_w = h[widx_m*WORD_W +: WORD_W];
      exp_l = (widx_m == NW - 1);
    end
    chk_eq("m_valid", m_valid, mq.size() != 0);
    chk_eq("m_last", m_last, exp_l);
    chk_eq("c2_m_valid", c2_m_valid, mq.size() != 0);
    chk_eq("c2_m_last", c2_m_last, exp_l);
    if (mq.size() != 0) begin
      chk_eq("m_data", m_data, exp_w);
      chk_eq("c2_m_data", c2_m_data, exp_w);
    end
    chk_eq("frame_cnt", frame_cnt, frames_m % 65536);
    chk_eq("frame_cnt_w2", c2_frame_cnt, frames_m % 4);
    chk_eq("overflow", overflow, ovf_m);
    chk_eq("c2_overflow", c2_overflow, ovf_m);
    chk_eq("fifo_level", fifo_level, mq.size());
    chk_eq("c2_fifo_level", c2_fifo_level, mq.size());
    if (prev_stall) begin
      chk_eq("hold_valid", m_valid, 1'b1);
      chk_eq("hold_data", m_data, prev_data);
      chk_eq("hold_last", m_last, prev_last);
    end

    valid_in = v;
    data_in  = d;
    m_ready  = r;
    prev_stall = m_valid && !r;
    prev_data  = m_data;
    prev_last  = m_last;
    if (m_valid && r) begin
      log_d.push_back(m_data);
      log_l.push_back(m_last);
    end

    full = (mq.size() == DEPTH);
    beat = (mq.size() != 0) && r;
    pop  = beat && (widx_m == NW - 1);
    if (beat) begin
      if (pop) begin
        widx_m = 0;
        frames_m++;
      end else begin
        widx_m++;
      end
    end
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (!full || pop) mq.push_back(d);
      else ovf_m = 1'b1;
    end
  endtask

  // Asynchronous reset asserted between clock edges, then released.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst_m_valid", m_valid, 1'b0);
    chk_eq("rst_m_last", m_last, 1'b0);
    chk_eq("rst_m_data", m_data, 32'd0);
    chk_eq("rst_frame_cnt", frame_cnt, 16'd0);
    chk_eq("rst_overflow", overflow, 1'b0);
    chk_eq("rst_fifo_level", fifo_level, 2'd0);
    chk_eq("rst_c2_frame_cnt", c2_frame_cnt, 2'd0);
    mq.delete();
    widx_m = 0;
    frames_m = 0;
    ovf_m = 1'b0;
    log_d.delete();
    log_l.delete();
    prev_stall = 1'b0;
    valid_in = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input int base, input logic [DATA_W-1:0] d);
    if (log_d.size() >= base + NW) begin
      for (int k = 0; k < NW; k++) begin
        chk_eq({tag, "_word"}, log_d[base+k], d[k*WORD_W +: WORD_W]);
        chk_eq({tag, "_last"}, log_l[base+k], k == NW - 1);
      end
    end else begin
      chk_eq({tag, "_short"}, log_d.size(), base + NW);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_result();
    logic [DATA_W-1:0] r;
    for (int k = 0; k < NW; k++) r[k*WORD_W +: WORD_W] = $urandom();
    return r;
  endfunction

  initial begin
    logic [DATA_W-1:0] f_seq, a, b, c, dd, g;
    logic [DATA_W-1:0] x[4];
    int                n;

    for (int k = 0; k < NW; k++) f_seq[k*WORD_W +: WORD_W] = 32'(k + 1);

    do_reset();
    cycle(1'b0, '0, 1'b0);

    // single frame, ready held high
    cycle(1'b1, f_seq, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1);
    chk_eq("single_frame_cnt", frame_cnt, 16'd1);
    chk_eq("single_beats", log_d.size(), NW);
    expect_frame("single", 0, f_seq);

    // backpressure with ready pattern 1,0,0,1
    do_reset();
    cycle(1'b1, f_seq, 1'b1);
    n = 0;
    while ((log_d.size() < NW) && (n < 40)) begin
      cycle(1'b0, '0, (n % 4 == 0) || (n % 4 == 3));
      n++;
    end
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk_eq("bp_beats", log_d.size(), NW);
    expect_frame("bp", 0, f_seq);

    // fill and overflow
    do_reset();
    a = rand_result(); b = rand_result(); c = rand_result();
    cycle(1'b1, a, 1'b0);
    cycle(1'b1, b, 1'b0);
    cycle(1'b1, c, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk_eq("ovf_level", fifo_level, 2'd2);
    chk_eq("ovf_flag", overflow, 1'b1);
    repeat (16) cycle(1'b0, '0, 1'b1);
    chk_eq("ovf_beats", log_d.size(), 2 * NW);
    expect_frame("ovf_a", 0, a);
    expect_frame("ovf_b", NW, b);
    chk_eq("ovf_sticky", overflow, 1'b1);

    // push coincident with the last beat of a full FIFO
    do_reset();
    a = rand_result(); b = rand_result(); dd = rand_result();
    cycle(1'b1, a, 1'b0);
    cycle(1'b1, b, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, dd, 1'b1);
    chk_eq("simul_last", m_last, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk_eq("simul_level", fifo_level, 2'd2);
    chk_eq("simul_ovf", overflow, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b1);
    expect_frame("simul_a", 0, a);
    expect_frame("simul_b", NW, b);
    expect_frame("simul_d", 2 * NW, dd);

    // spaced frames, then a fourth to wrap the 2-bit counter
    do_reset();
    for (int i = 0; i < 4; i++) x[i] = rand_result();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, x[i], 1'b1);
      repeat (9) cycle(1'b0, '0, 1'b1);
    end
    chk_eq("b2b_frame_cnt", frame_cnt, 16'd3);
    chk_eq("b2b_beats", log_d.size(), 3 * NW);
    for (int i = 0; i < 3; i++) expect_frame("b2b", i * NW, x[i]);
    cycle(1'b1, x[3], 1'b1);
    repeat (9) cycle(1'b0, '0, 1'b1);
    chk_eq("wrap_frame_cnt", frame_cnt, 16'd4);
    chk_eq("wrap_c2_frame_cnt", c2_frame_cnt, 2'd0);

    // queued frames stream with no bubble between them
    do_reset();
    a = rand_result(); b = rand_result();
    cycle(1'b1, a, 1'b0);
    cycle(1'b1, b, 1'b0);
    repeat (2 * NW) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk_eq("nobubble_beats", log_d.size(), 2 * NW);
    expect_frame("nobubble_a", 0, a);
    expect_frame("nobubble_b", NW, b);

    // reset in the middle of a frame
    do_reset();
    cycle(1'b1, f_seq, 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk_eq("mid_words", log_d.size(), 4);
    chk_eq("mid_word3", log_d[3], 32'd4);
    do_reset();
    g = rand_result();
    cycle(1'b1, g, 1'b1);
    repeat (8) cycle(1'b0, '0, 1'b1);
    expect_frame("mid_new", 0, g);
    chk_eq("mid_frame_cnt", frame_cnt, 16'd1);

    // random traffic with alternating light and heavy backpressure
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ((i / 250) % 2 == 0) begin
        cycle($urandom_range(0, 3) == 0, rand_result(), $urandom_range(0, 3) != 0);
      end else begin
        cycle($urandom_range(0, 5) == 0, rand_result(), $urandom_range(0, 3) == 0);
      end
    end
    repeat (40) cycle(1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
